// File: rtl/result_piso_pkg.sv
// rtl/result_piso_pkg.sv - shared state type and serial word length for result_piso
// RESULT_PISO_PARITY_EN adds one even-parity bit after the data bits.
package result_piso_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  function automatic int nbits_f(input int width);
`ifdef RESULT_PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/result_piso_bit_timer.sv
// rtl/result_piso_bit_timer.sv - modulo-period_p counter pacing each serial bit
// wrap_o flags the terminal cycle of a period while enabled.
module bit_timer #(
  parameter int period_p = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  input  logic clear_i,
  output logic wrap_o
);

  localparam int cnt_w_lp = (period_p > 1) ? $clog2(period_p) : 1;

  logic [cnt_w_lp-1:0] cnt_r;

  // With period_p == 1 the compare is against zero, so cnt_r never leaves 0.
  assign wrap_o = en_i & (cnt_r == cnt_w_lp'(period_p - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r <= '0;
    end else if (clear_i || wrap_o) begin
      cnt_r <= '0;
    end else if (en_i) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

endmodule

// File: rtl/result_piso.sv
// rtl/result_piso.sv - pops result words and shifts them out one slow bit at a time
// Optional even-parity trailer bit when RESULT_PISO_PARITY_EN is defined.
module result_piso
  import result_piso_pkg::*;
#(
  parameter int   width_p      = 8,
  parameter int   num_words_p  = 4,
  parameter int   bit_period_p = 16,
  parameter logic msb_first_p  = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               yumi_o,
  output logic               valid_o,
  output logic               data_o,
  output logic               last_o,
  output logic               frame_done_o,
  output logic               busy_o
);

  localparam int nbits_lp      = nbits_f(width_p);
  localparam int bit_cnt_w_lp  = $clog2(nbits_lp + 1);
  localparam int word_cnt_w_lp = (num_words_p > 1) ? $clog2(num_words_p) : 1;

  state_e                   state_r, state_n;
  logic [nbits_lp-1:0]      shift_r;
  logic [nbits_lp-1:0]      load_word;
  logic [bit_cnt_w_lp-1:0]  bit_cnt_r;
  logic [word_cnt_w_lp-1:0] word_cnt_r;
  logic                     shifting;
  logic                     bit_wrap;
  logic                     last_bit;
  logic                     word_end;
  logic                     frame_end;
  logic                     accept;

  assign shifting = (state_r == SHIFT);
  assign accept   = (state_r == IDLE) & valid_i & ~flush_i;

  bit_timer #(
    .period_p (bit_period_p)
  ) u_bit_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (shifting),
    .clear_i   (flush_i | accept),
    .wrap_o    (bit_wrap)
  );

  // Parity sits at the end of the shift path for either shift direction.
`ifdef RESULT_PISO_PARITY_EN
  assign load_word = msb_first_p ? {data_i, ^data_i} : {^data_i, data_i};
`else
  assign load_word = data_i;
`endif

  assign last_bit  = shifting & (bit_cnt_r == bit_cnt_w_lp'(nbits_lp - 1));
  assign word_end  = last_bit & bit_wrap;
  assign frame_end = word_end & (word_cnt_r == word_cnt_w_lp'(num_words_p - 1));

  assign yumi_o       = accept & reset_n_i;
  assign frame_done_o = frame_end & ~flush_i;
  assign valid_o      = shifting;
  assign busy_o       = shifting;
  assign last_o       = last_bit;
  assign data_o       = shifting & (msb_first_p ? shift_r[nbits_lp-1] : shift_r[0]);

  always_comb begin
    state_n = state_r;
    if (flush_i) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (valid_i)  state_n = SHIFT;
        SHIFT:   if (word_end) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      word_cnt_r <= '0;
    end else if (flush_i) begin
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      word_cnt_r <= '0;
    end else if (accept) begin
      shift_r   <= load_word;
      bit_cnt_r <= '0;
    end else if (bit_wrap) begin
      shift_r   <= msb_first_p ? (shift_r << 1) : (shift_r >> 1);
      bit_cnt_r <= word_end ? '0 : bit_cnt_r + 1'b1;
      if (word_end) begin
        word_cnt_r <= frame_end ? '0 : word_cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_piso.sv
// tb/tb_result_piso.sv - randomized, model-checked bench for result_piso
// Instance 0: MSB-first, 2-cycle bits. Instance 1: LSB-first, 3-cycle bits.
module tb_result_piso;

  localparam int W  = 8;
  localparam int NW = 4;
`ifdef RESULT_PISO_PARITY_EN
  localparam int NB = W + 1;
  localparam logic [31:0] EXP_A = 32'h000330CC;
  localparam logic [31:0] EXP_B = 32'h07000007;
`else
  localparam int NB = W;
  localparam logic [31:0] EXP_A = 32'h0000CC33;
  localparam logic [31:0] EXP_B = 32'h00E00000;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   vin = 2'b00;
  logic [W-1:0] din [2];
  logic [1:0]   yumi, vout, dout, last, fd, busy;
  logic [1:0]   s_yumi, s_valid, s_data, s_last, s_fd, s_busy;

  int checks;
  int failures;

  bit           m_busy [2];
  int           m_t    [2];
  int           m_wc   [2];
  logic [W-1:0] m_w    [2];

  always #5 clk = ~clk;

  result_piso #(.width_p(W), .num_words_p(NW), .bit_period_p(2), .msb_first_p(1'b1)) dut_msb (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .valid_i(vin[0]), .data_i(din[0]),
    .yumi_o(yumi[0]), .valid_o(vout[0]), .data_o(dout[0]), .last_o(last[0]),
    .frame_done_o(fd[0]), .busy_o(busy[0]));

  result_piso #(.width_p(W), .num_words_p(NW), .bit_period_p(3), .msb_first_p(1'b0)) dut_lsb (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .valid_i(vin[1]), .data_i(din[1]),
    .yumi_o(yumi[1]), .valid_o(vout[1]), .data_o(dout[1]), .last_o(last[1]),
    .frame_done_o(fd[1]), .busy_o(busy[1]));

  function automatic int per_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  // k-th transmitted bit of word w: data bits in shift order, then parity.
  function automatic logic bit_of(input logic [W-1:0] w, input int k, input bit msb);
    if (k >= W) return ^w;
    else if (msb) return w[W-1-k];
    else return w[k];
  endfunction

  task automatic check_bit(input string name, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] at %0t: got %b expected %b", name, inst, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic ey, ev, ed, el, ef;
      int   bi;
      ey = 1'b0; ev = 1'b0; ed = 1'b0; el = 1'b0; ef = 1'b0; bi = 0;
      if (reset_n) begin
        if (m_busy[i]) begin
          bi = m_t[i] / per_of(i);
          ev = 1'b1;
          ed = bit_of(m_w[i], bi, i == 0);
          el = (bi == NB - 1);
          ef = !flush && (m_t[i] == NB * per_of(i) - 1) && (m_wc[i] == NW - 1);
        end else begin
          ey = vin[i] && !flush;
        end
      end
      check_bit("yumi_o", i, yumi[i], ey);
      check_bit("valid_o", i, vout[i], ev);
      check_bit("data_o", i, dout[i], ed);
      check_bit("last_o", i, last[i], el);
      check_bit("frame_done_o", i, fd[i], ef);
      check_bit("busy_o", i, busy[i], ev);
      s_yumi[i] = yumi[i]; s_valid[i] = vout[i]; s_data[i] = dout[i];
      s_last[i] = last[i]; s_fd[i] = fd[i]; s_busy[i] = busy[i];
    end
  endtask

  task automatic advance();
    for (int i = 0; i < 2; i++) begin
      if (!reset_n || flush) begin
        m_busy[i] = 1'b0;
        m_wc[i]   = 0;
      end else if (m_busy[i]) begin
        if (m_t[i] == NB * per_of(i) - 1) begin
          m_busy[i] = 1'b0;
          m_wc[i]   = (m_wc[i] + 1) % NW;
        end else begin
          m_t[i]++;
        end
      end else if (vin[i]) begin
        m_busy[i] = 1'b1;
        m_t[i]    = 0;
        m_w[i]    = din[i];
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic run_frame(input string tag);
    logic [W-1:0] words [4];
    int idx, n_y, n_fd, fd_c, prev_y, pitch_bad;
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    idx = 0; n_y = 0; n_fd = 0; fd_c = -1; prev_y = -1; pitch_bad = 0;
    vin[0] = 1'b1;
    din[0] = words[0];
    for (int c = 0; c < 4 * (NB * 2 + 1) + 8; c++) begin
      tick();
      if (s_fd[0]) begin
        n_fd++;
        fd_c = c;
      end
      if (s_yumi[0]) begin
        if (prev_y >= 0 && c - prev_y != NB * 2 + 1) pitch_bad++;
        prev_y = c;
        n_y++;
        idx++;
        if (idx < 4) din[0] = words[idx];
        else vin[0] = 1'b0;
      end
    end
    check_int({tag, "_yumi_pulses"}, n_y, 4);
    check_int({tag, "_pitch_errors"}, pitch_bad, 0);
    check_int({tag, "_frame_done_pulses"}, n_fd, 1);
    check_int({tag, "_frame_done_cycle"}, fd_c, prev_y + NB * 2);
  endtask

  initial begin
    logic [31:0] seq0, seq1;
    int vc0, vc1, lc0, lc1, n, fd_seen;
    checks = 0; failures = 0;
    din[0] = '0; din[1] = '0;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_t[i] = 0; m_wc[i] = 0; m_w[i] = '0;
    end

    // Reset: yumi_o must stay low even with valid_i high.
    repeat (2) tick();
    vin = 2'b11;
    tick();
    check_bit("reset_yumi", 0, s_yumi[0], 1'b0);
    check_bit("reset_yumi", 1, s_yumi[1], 1'b0);
    reset_n = 1'b1;
    vin = 2'b00;
    tick();

    // Single word on both instances: 8'hA5 MSB-first, 8'h01 LSB-first.
    vin = 2'b11; din[0] = 8'hA5; din[1] = 8'h01;
    tick();
    check_bit("accept_yumi", 0, s_yumi[0], 1'b1);
    check_bit("accept_yumi", 1, s_yumi[1], 1'b1);
    vin = 2'b00;
    seq0 = '0; seq1 = '0; vc0 = 0; vc1 = 0; lc0 = 0; lc1 = 0;
    for (int c = 0; c < NB * 3; c++) begin
      tick();
      if (c < NB * 2) seq0 = {seq0[30:0], s_data[0]};
      seq1 = {seq1[30:0], s_data[1]};
      vc0 += int'(s_valid[0]); vc1 += int'(s_valid[1]);
      lc0 += int'(s_last[0]);  lc1 += int'(s_last[1]);
    end
    check_int("msb_bit_stream", int'(seq0), int'(EXP_A));
    check_int("lsb_bit_stream", int'(seq1), int'(EXP_B));
    check_int("msb_valid_cycles", vc0, NB * 2);
    check_int("lsb_valid_cycles", vc1, NB * 3);
    check_int("msb_last_cycles", lc0, 2);
    check_int("lsb_last_cycles", lc1, 3);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_frame("frame");

    // Flush during bit 3 of the second word: word discarded, no frame_done_o.
    vin[0] = 1'b1; din[0] = 8'h5A; n = 0; fd_seen = 0;
    for (int c = 0; c < 100 && n < 2; c++) begin
      tick();
      fd_seen += int'(s_fd[0]);
      if (s_yumi[0]) begin
        n++;
        din[0] = 8'h3C;
      end
    end
    check_int("flush_setup_words", n, 2);
    vin[0] = 1'b0;
    repeat (6) begin
      tick();
      fd_seen += int'(s_fd[0]);
    end
    flush = 1'b1;
    tick();
    fd_seen += int'(s_fd[0]);
    flush = 1'b0;
    tick();
    fd_seen += int'(s_fd[0]);
    check_bit("flush_valid_after", 0, s_valid[0], 1'b0);
    check_int("flush_frame_done", fd_seen, 0);
    run_frame("post_flush");

    // Asynchronous reset mid-word: outputs drop before any clock edge.
    vin = 2'b11; din[0] = 8'hFF; din[1] = 8'hC3; n = 0;
    for (int c = 0; c < 50 && n == 0; c++) begin
      tick();
      if (s_yumi[0]) n++;
    end
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_bit("async_rst_yumi", i, yumi[i], 1'b0);
      check_bit("async_rst_valid", i, vout[i], 1'b0);
      check_bit("async_rst_data", i, dout[i], 1'b0);
      check_bit("async_rst_last", i, last[i], 1'b0);
      check_bit("async_rst_fd", i, fd[i], 1'b0);
      check_bit("async_rst_busy", i, busy[i], 1'b0);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check_bit("release_yumi", 0, s_yumi[0], 1'b1);
    check_bit("release_yumi", 1, s_yumi[1], 1'b1);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 4000; c++) begin
      vin[0] = ($urandom_range(0, 9) < 7);
      vin[1] = ($urandom_range(0, 9) < 7);
      din[0] = W'($urandom);
      din[1] = W'($urandom);
      flush  = ($urandom_range(0, 149) == 0);
      tick();
    end
    flush = 1'b0;
    vin = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_piso.md
# result_piso

Parallel-in/serial-out transmitter for systolic-array results: the output-side counterpart of the bit-serial button entry path. It pops width_p-bit words from the result FIFO using valid/yumi, then shifts each word out one bit at a time. Each bit is held for a programmable number of cycles, so the stream can drive an LED or a slow external receiver. It counts words per matrix and pulses a frame-done strobe after the last result.

## Interface
- width_p, 8, bits per result word
- num_words_p, 4, words per matrix frame (array_width × array_height)
- bit_period_p, 16, clk_i cycles each bit is held; must be ≥1
- msb_first_p, 1'b1, 1 = shift MSB first, 0 = LSB first

- clk_i  in  1  single clock
- reset_n_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous abort; returns to IDLE and clears the frame count
- valid_i  in  1  FIFO has a word
- data_i  in  width_p  FIFO head word
- yumi_o  out  1  word consumed this cycle
- valid_o  out  1  data_o carries a live bit
- data_o  out  1  serial bit
- last_o  out  1  data_o is the final bit of the current word
- frame_done_o  out  1  one-cycle pulse when the last word of a frame finishes
- busy_o  out  1  a word is being shifted

## Operation
- States: IDLE and SHIFT.
- IDLE:
  - yumi_o = valid_i & ~flush_i (combinational).
  - When yumi_o is high, data_i is captured into shift_r, bit_cnt = 0, per_cnt = 0, and the state moves to SHIFT.
- SHIFT:
  - valid_o = 1, busy_o = 1, yumi_o = 0.
  - data_o = shift_r[width_p-1] when msb_first_p, else shift_r[0].
  - per_cnt increments each cycle. When per_cnt == bit_period_p-1, per_cnt clears, shift_r shifts by one, and bit_cnt increments.
- Word end:
  - Occurs on the terminal period cycle of the last bit; bit index = nbits_w-1, where nbits_w = width_p, or width_p+1 with parity.
  - The state returns to IDLE and word_cnt increments.
  - If word_cnt == num_words_p-1, frame_done_o pulses that same cycle and word_cnt wraps to 0.
- last_o = 1 for every cycle of bit nbits_w-1.
- valid_o, data_o, last_o and busy_o are driven from registered state only; they have no combinational path from inputs.
- flush_i has priority over every other event:
  - Next cycle: state IDLE, word_cnt = 0, shift_r = 0.
  - A word that is mid-shift is discarded without frame_done_o.
  - No yumi_o is issued in the flush cycle.
- reset_n_i low (any time, including mid-word): all outputs are 0 immediately, state is IDLE, and all counters are 0.
- frame_done_o and a new yumi_o cannot coincide, because the block is in SHIFT when the frame ends.

## Timing
- Reset values: yumi_o 0, valid_o 0, data_o 0, last_o 0, frame_done_o 0, busy_o 0.
- Accept at edge k → first bit on data_o from cycle k+1.
- Each bit is held exactly bit_period_p cycles.
- valid_o is high for nbits_w × bit_period_p cycles per word.
- Back-to-back words: at least one IDLE cycle between words. Word pitch = nbits_w × bit_period_p + 1 cycles when valid_i stays high.
- bit_period_p = 1: one bit per cycle, and per_cnt is a constant 0.
- Counter widths: per_cnt $clog2(bit_period_p) (min 1), bit_cnt $clog2(nbits_w+1), word_cnt $clog2(num_words_p) (min 1).

## Configuration
- RESULT_PISO_PARITY_EN defined:
  - After the width_p data bits, one extra bit equal to ^word (even parity) is sent, held for bit_period_p cycles.
  - last_o marks the parity bit; nbits_w = width_p+1.
- Undefined: no parity bit; nbits_w = width_p, and last_o marks the final data bit.

## Structure
- Package result_piso_pkg holds:
  - state_e enum {IDLE, SHIFT}
  - the nbits_w computation as a function of width_p and the macro.
- Sub-module bit_timer: a modulo-bit_period_p counter with en_i/clear_i and a terminal-count output wrap_o. It is reused by the frame/word logic.
- Everything else lives in result_piso.

## Test plan
- **Basic word:** bit_period_p=2, msb_first_p=1, data_i=8'hA5 with valid_i one cycle.
  - Response: yumi_o 1 cycle; data_o = 1,0,1,0,0,1,0,1 with each bit 2 cycles.
  - valid_o high 16 cycles; last_o high on the final 2 cycles.
- **LSB-first:** msb_first_p=0, data_i=8'h01.
  - Response: data_o 1 for the first bit_period_p cycles, then 0 for the remaining 7 bits.
- **Frame:** num_words_p=4, four words 8'h11, 8'h22, 8'h33, 8'h44 present continuously.
  - Response: four yumi_o pulses, 8×bit_period_p+1 cycles apart.
  - frame_done_o pulses exactly once, on the last cycle of 8'h44.
- **Flush:** flush_i asserted on bit 3 of word 2.
  - Response: valid_o 0 next cycle, no frame_done_o.
  - The next four words produce frame_done_o on the fourth word.
- **Async reset:** reset_n_i pulled low mid-bit, asynchronous to the clock edge.
  - Response: all outputs 0 immediately.
  - After release with valid_i high, yumi_o is 1 on the first clocked cycle.
- **Parity (RESULT_PISO_PARITY_EN):** data_i=8'h07.
  - Response: 9 bits, ninth bit = 1, last_o on the ninth bit.
  - data_i=8'hA5 gives a ninth bit of 0.
